// File: rtl/display_pkg.sv
// Shared constants, types and the seven-segment glyph table for the display scan controller.
package display_pkg;

  localparam int NUM_DIGITS = 8;
  localparam int SEL_W      = 3;
  localparam int NIB_W      = 4;
  localparam int DATA_W     = NUM_DIGITS * NIB_W;

  typedef logic [6:0] seg_t;

  // One complete display image as offered by the host and held in the buffers.
  typedef struct packed {
    logic [DATA_W-1:0]     data;
    logic [NUM_DIGITS-1:0] dp;
    logic [NUM_DIGITS-1:0] en;
  } image_t;

  // Active-high {g,f,e,d,c,b,a} glyphs for hex digits 0..F.
  localparam seg_t SEG_TABLE [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

endpackage

// File: rtl/seg7_decode.sv
// Combinational hex nibble to active-high gfedcba segment decoder.
module seg7_decode
  import display_pkg::*;
(
  input  logic [NIB_W-1:0] nib,
  output seg_t             seg
);

  assign seg = SEG_TABLE[nib];

endmodule

// File: rtl/display_scan_ctrl.sv
// Time-multiplexed 8-digit seven-segment scan controller with anode dead-time,
// double-buffered host image and leading-zero suppression.
module display_scan_ctrl
  import display_pkg::*;
#(
  parameter int unsigned REFRESH_DIV      = 100000,
  parameter int unsigned BLANK_CYCLES     = 1000,
  parameter bit          ANODE_ACTIVE_LOW = 1'b1,
  parameter bit          SEG_ACTIVE_LOW   = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load_valid,
  output logic                  load_ready,
  input  logic [DATA_W-1:0]     load_data,
  input  logic [NUM_DIGITS-1:0] load_dp,
  input  logic [NUM_DIGITS-1:0] load_en,
  input  logic                  lz_suppress,
  output logic [SEL_W-1:0]      digit_sel,
  output logic [NUM_DIGITS-1:0] an,
  output seg_t                  seg,
  output logic                  dp,
  output logic                  frame_tick
);

  localparam int unsigned PRE_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(REFRESH_DIV - 1);
  localparam logic [SEL_W-1:0] SEL_LAST = SEL_W'(NUM_DIGITS - 1);

  // Inactive pin levels; XOR-ing an active-high value with these applies the polarity.
  localparam logic [NUM_DIGITS-1:0] AN_OFF  = ANODE_ACTIVE_LOW ? '1 : '0;
  localparam seg_t                  SEG_OFF = SEG_ACTIVE_LOW ? '1 : '0;
  localparam logic                  DP_OFF  = SEG_ACTIVE_LOW;

  logic [PRE_W-1:0]      prescaler;
  logic                  slot_wrap;
  logic                  frame_wrap;
  logic                  pending;
  image_t                pending_img;
  image_t                active_img;
  logic [NIB_W-1:0]      nib;
  seg_t                  dec_seg;
  logic                  upper_zero;
  logic                  suppressed;
  logic [NUM_DIGITS-1:0] an_lit;
  seg_t                  seg_lit;
  logic                  dp_lit;

  assign slot_wrap  = (prescaler == PRE_LAST);
  assign frame_wrap = slot_wrap && (digit_sel == SEL_LAST);
  assign load_ready = ~pending;

  // Slot prescaler and digit scan counter; frame_tick marks the 7 -> 0 wrap.
  always_ff @(posedge clk) begin
    if (rst) begin
      prescaler  <= '0;
      digit_sel  <= '0;
      frame_tick <= 1'b0;
    end else begin
      if (slot_wrap) begin
        prescaler <= '0;
        digit_sel <= digit_sel + 1'b1;
      end else begin
        prescaler <= prescaler + 1'b1;
      end
      frame_tick <= frame_wrap;
    end
  end

  // Host image is parked in the pending buffer and only promoted at a frame boundary.
  always_ff @(posedge clk) begin
    if (rst) begin
      pending     <= 1'b0;
      pending_img <= '0;
      active_img  <= '0;
    end else if (frame_wrap && pending) begin
      active_img <= pending_img;
      pending    <= 1'b0;
    end else if (load_valid && load_ready) begin
      pending_img <= '{data: load_data, dp: load_dp, en: load_en};
      pending     <= 1'b1;
    end
  end

  seg7_decode u_decode (
    .nib (nib),
    .seg (dec_seg)
  );

  // Active-high pin values for the current slot: glyph, suppression, enable and dead-time.
  always_comb begin
    nib        = active_img.data[NIB_W*digit_sel +: NIB_W];
    upper_zero = ((active_img.data >> (NIB_W*digit_sel)) == '0);
    suppressed = lz_suppress && (digit_sel != '0) && upper_zero;
    seg_lit    = '0;
    dp_lit     = 1'b0;
    if (active_img.en[digit_sel]) begin
      dp_lit = active_img.dp[digit_sel];
      if (!suppressed) begin
        seg_lit = dec_seg;
      end
    end
    an_lit = '0;
    if (32'(prescaler) >= BLANK_CYCLES) begin
      an_lit[digit_sel] = 1'b1;
    end
  end

  // Registered pin drivers with polarity applied.
  always_ff @(posedge clk) begin
    if (rst) begin
      an  <= AN_OFF;
      seg <= SEG_OFF;
      dp  <= DP_OFF;
    end else begin
      an  <= an_lit ^ AN_OFF;
      seg <= seg_lit ^ SEG_OFF;
      dp  <= dp_lit ^ DP_OFF;
    end
  end

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Self-checking bench for display_scan_ctrl: table vectors, handshake corner
// sequences and randomized traffic against a cycle-indexed reference model.
module tb_display_scan_ctrl;

  localparam int RDIV  = 4;
  localparam int BLANK = 1;
  localparam int FRAME = RDIV * 8;

  logic        clk;
  logic        rst;
  logic        load_valid;
  logic        load_ready;
  logic [31:0] load_data;
  logic [7:0]  load_dp;
  logic [7:0]  load_en;
  logic        lz_suppress;
  logic [2:0]  digit_sel;
  logic [7:0]  an;
  logic [6:0]  seg;
  logic        dp;
  logic        frame_tick;

  int vectors;
  int miscompares;

  display_scan_ctrl #(
    .REFRESH_DIV      (RDIV),
    .BLANK_CYCLES     (BLANK),
    .ANODE_ACTIVE_LOW (1'b1),
    .SEG_ACTIVE_LOW   (1'b1)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .load_valid  (load_valid),
    .load_ready  (load_ready),
    .load_data   (load_data),
    .load_dp     (load_dp),
    .load_en     (load_en),
    .lz_suppress (lz_suppress),
    .digit_sel   (digit_sel),
    .an          (an),
    .seg         (seg),
    .dp          (dp),
    .frame_tick  (frame_tick)
  );

  // Free-running clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct packed {
    logic [31:0] data;
    logic [7:0]  dp;
    logic [7:0]  en;
  } image_t;

  typedef struct {
    logic [31:0] data;
    logic [7:0]  dpm;
    logic [7:0]  en;
    logic        lz;
    int          digit;
    logic [6:0]  exp_seg;
    logic        exp_dp;
  } vec_t;

  vec_t vecs [14];

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, actual, expected, $time);
    end
  endtask

  function automatic logic [6:0] segLit(input logic [3:0] n);
    case (n)
      4'h0: return 7'h3F;  4'h1: return 7'h06;  4'h2: return 7'h5B;  4'h3: return 7'h4F;
      4'h4: return 7'h66;  4'h5: return 7'h6D;  4'h6: return 7'h7D;  4'h7: return 7'h07;
      4'h8: return 7'h7F;  4'h9: return 7'h6F;  4'hA: return 7'h77;  4'hB: return 7'h7C;
      4'hC: return 7'h39;  4'hD: return 7'h5E;  4'hE: return 7'h79;  default: return 7'h71;
    endcase
  endfunction

  // Pin-level segment/dp for one digit of an image, following the display rules directly.
  function automatic void renderDigit(input image_t img, input int slot, input logic lz,
                                      output logic [6:0] s, output logic d);
    logic [3:0] n;
    logic       upper_zero;
    logic [6:0] lit;
    logic       d_on;
    n = img.data[slot*4 +: 4];
    upper_zero = 1'b1;
    for (int k = slot; k < 8; k++) begin
      if (img.data[k*4 +: 4] != 4'h0) upper_zero = 1'b0;
    end
    lit  = segLit(n);
    d_on = 1'b0;
    if (!img.en[slot]) begin
      lit = 7'h00;
    end else begin
      d_on = img.dp[slot];
      if (lz && slot != 0 && upper_zero) lit = 7'h00;
    end
    s = ~lit;
    d = ~d_on;
  endfunction

  // Reference model: m_t is the number of cycles since the last reset edge.
  image_t     m_active;
  image_t     m_pend;
  bit         m_pend_v;
  bit         m_valid;
  int         m_t;
  logic [7:0] e_an;
  logic [6:0] e_seg;
  logic       e_dp;

  initial begin
    m_valid = 1'b0;
    m_t     = 0;
  end

  // Advance the model at each clock edge using the inputs seen before the edge.
  always @(posedge clk) begin
    int slot;
    int phase;
    if (rst) begin
      m_valid  = 1'b1;
      m_t      = 0;
      m_active = '0;
      m_pend   = '0;
      m_pend_v = 1'b0;
      e_an     = 8'hFF;
      e_seg    = 7'h7F;
      e_dp     = 1'b1;
    end else if (m_valid) begin
      slot  = (m_t / RDIV) % 8;
      phase = m_t % RDIV;
      e_an  = (phase >= BLANK) ? ~(8'h01 << slot) : 8'hFF;
      renderDigit(m_active, slot, lz_suppress, e_seg, e_dp);
      if ((m_t % FRAME) == FRAME - 1 && m_pend_v) begin
        m_active = m_pend;
        m_pend_v = 1'b0;
      end else if (load_valid && !m_pend_v) begin
        m_pend   = '{data: load_data, dp: load_dp, en: load_en};
        m_pend_v = 1'b1;
      end
      m_t++;
    end
  end

  // Compare every observable output against the model mid-cycle.
  always @(negedge clk) begin
    if (m_valid) begin
      checkOutput("digit_sel", {29'd0, digit_sel}, (m_t / RDIV) % 8);
      checkOutput("frame_tick", {31'd0, frame_tick}, {31'd0, (m_t > 0) && (m_t % FRAME == 0)});
      checkOutput("load_ready", {31'd0, load_ready}, {31'd0, !m_pend_v});
      checkOutput("an", {24'd0, an}, {24'd0, e_an});
      checkOutput("seg", {25'd0, seg}, {25'd0, e_seg});
      checkOutput("dp", {31'd0, dp}, {31'd0, e_dp});
    end
  end

  // Hang guard.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog expired at %0t", $time);
    $fatal(1, "[TB] watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [31:0] data, input logic [7:0] dpm, input logic [7:0] en);
    for (int i = 0; i < 80 && !load_ready; i++) step();
    checkOutput("ready_wait", {31'd0, load_ready}, 32'd1);
    load_valid = 1'b1;
    load_data  = data;
    load_dp    = dpm;
    load_en    = en;
    step();
    load_valid = 1'b0;
  endtask

  task automatic waitTick(input string name);
    for (int i = 0; i < FRAME + 8 && !frame_tick; i++) step();
    checkOutput(name, {31'd0, frame_tick}, 32'd1);
  endtask

  task automatic waitDigit(input int d);
    logic [7:0] want;
    want = ~(8'h01 << d);
    for (int i = 0; i < FRAME + 8 && an != want; i++) step();
    checkOutput("digit_slot", {24'd0, an}, {24'd0, want});
  endtask

  initial begin
    int n;
    vectors     = 0;
    miscompares = 0;
    rst         = 1'b1;
    load_valid  = 1'b0;
    load_data   = '0;
    load_dp     = '0;
    load_en     = '0;
    lz_suppress = 1'b0;

    vecs[0]  = '{32'h12345678, 8'h00, 8'hFF, 1'b0, 0, 7'h00, 1'b1};
    vecs[1]  = '{32'h12345678, 8'h00, 8'hFF, 1'b0, 7, 7'h79, 1'b1};
    vecs[2]  = '{32'h000000A0, 8'h04, 8'hFF, 1'b1, 2, 7'h7F, 1'b0};
    vecs[3]  = '{32'h000000A0, 8'h04, 8'hFF, 1'b1, 1, 7'h08, 1'b1};
    vecs[4]  = '{32'h000000A0, 8'h04, 8'hFF, 1'b1, 0, 7'h40, 1'b1};
    vecs[5]  = '{32'h000000A0, 8'h04, 8'hFF, 1'b1, 7, 7'h7F, 1'b1};
    vecs[6]  = '{32'h000000A0, 8'h04, 8'hFF, 1'b0, 7, 7'h40, 1'b1};
    vecs[7]  = '{32'hFEDCBA98, 8'hFF, 8'hFF, 1'b0, 3, 7'h03, 1'b0};
    vecs[8]  = '{32'hFEDCBA98, 8'hFF, 8'hFF, 1'b0, 5, 7'h21, 1'b0};
    vecs[9]  = '{32'hFEDCBA98, 8'hFF, 8'hF7, 1'b0, 3, 7'h7F, 1'b1};
    vecs[10] = '{32'h00000000, 8'h00, 8'hFF, 1'b1, 0, 7'h40, 1'b1};
    vecs[11] = '{32'h30000000, 8'h00, 8'hFF, 1'b1, 7, 7'h30, 1'b1};
    vecs[12] = '{32'h30000000, 8'h00, 8'hFF, 1'b1, 6, 7'h40, 1'b1};
    vecs[13] = '{32'hE0000000, 8'h00, 8'hFF, 1'b1, 7, 7'h06, 1'b1};

    // Reset values and first frame_tick latency.
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    checkOutput("rst_an", {24'd0, an}, 32'hFF);
    checkOutput("rst_seg", {25'd0, seg}, 32'h7F);
    checkOutput("rst_dp", {31'd0, dp}, 32'd1);
    checkOutput("rst_ready", {31'd0, load_ready}, 32'd1);
    checkOutput("rst_sel", {29'd0, digit_sel}, 32'd0);
    n = 0;
    for (int i = 0; i < FRAME + 8 && !frame_tick; i++) begin
      step();
      n++;
    end
    checkOutput("first_tick_delay", n, FRAME);

    // Table-driven digit vectors: load, wait for commit, inspect one slot.
    foreach (vecs[i]) begin
      lz_suppress = vecs[i].lz;
      applyStimulus(vecs[i].data, vecs[i].dpm, vecs[i].en);
      waitTick("vec_commit");
      step();
      waitDigit(vecs[i].digit);
      checkOutput("vec_seg", {25'd0, seg}, {25'd0, vecs[i].exp_seg});
      checkOutput("vec_dp", {31'd0, dp}, {31'd0, vecs[i].exp_dp});
    end

    // Second load while busy is ignored; first one commits at the boundary.
    lz_suppress = 1'b0;
    waitTick("t4_align");
    applyStimulus(32'h00000005, 8'h00, 8'hFF);
    checkOutput("t4_ready_low", {31'd0, load_ready}, 32'd0);
    repeat (4) step();
    load_valid = 1'b1;
    load_data  = 32'h00000001;
    step();
    load_valid = 1'b0;
    waitTick("t4_commit");
    checkOutput("t4_ready_after_commit", {31'd0, load_ready}, 32'd1);
    step();
    waitDigit(0);
    checkOutput("t4_seg_is_A", {25'd0, seg}, 32'h12);

    // Reset discards a pending image; a load in the boundary cycle waits a frame.
    waitTick("t6_align");
    applyStimulus(32'h88888888, 8'hFF, 8'hFF);
    repeat (20) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    checkOutput("t6_ready", {31'd0, load_ready}, 32'd1);
    checkOutput("t6_an", {24'd0, an}, 32'hFF);
    waitTick("t6_tick1");
    repeat (FRAME - 1) step();
    checkOutput("t6_blank", {25'd0, seg}, 32'h7F);
    applyStimulus(32'h00000007, 8'h00, 8'hFF);
    checkOutput("t6_tick2", {31'd0, frame_tick}, 32'd1);
    checkOutput("t6_not_committed", {31'd0, load_ready}, 32'd0);
    step();
    waitTick("t6_tick3");
    checkOutput("t6_committed", {31'd0, load_ready}, 32'd1);
    step();
    waitDigit(0);
    checkOutput("t6_seg_7", {25'd0, seg}, 32'h78);

    // Randomized traffic, occasional resets and live lz_suppress changes.
    for (int c = 0; c < 3000; c++) begin
      rst        = ($urandom_range(0, 299) == 0);
      load_valid = ($urandom_range(0, 3) == 0);
      load_data  = $urandom >> $urandom_range(0, 31);
      load_dp    = 8'($urandom);
      load_en    = ($urandom_range(0, 1) == 0) ? 8'hFF : 8'($urandom);
      if ($urandom_range(0, 49) == 0) lz_suppress = ~lz_suppress;
      step();
    end
    rst        = 1'b0;
    load_valid = 1'b0;
    step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
